// File: rtl/video_linebuf_palette_pkg.sv
// rtl/video_linebuf_palette_pkg.sv - shared video constants, RGB type and line counter helper
package video_linebuf_palette_pkg;

  localparam int IDX_W   = 10;
  localparam int PIX_W   = 8;
  localparam int RGB_W   = 12;
  localparam int LINE_W  = 10;
  localparam int V_TOTAL = 525;

  // 640x480@60 timing, shared with the VGA timing stage
  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  function automatic logic [LINE_W-1:0] next_line(input logic [LINE_W-1:0] line);
    return (line == LINE_W'(V_TOTAL - 1)) ? '0 : line + 1'b1;
  endfunction

endpackage

// File: rtl/video_linebuf_palette_if.sv
// rtl/video_linebuf_palette_if.sv - composer/palette/display signals of the line buffer
interface video_linebuf_palette_if;
  import video_linebuf_palette_pkg::*;

  logic              lb_wr_en;
  logic [IDX_W-1:0]  lb_wr_idx;
  logic [PIX_W-1:0]  lb_wr_data;
  logic              pal_wr_en;
  logic [PIX_W-1:0]  pal_wr_addr;
  logic [RGB_W-1:0]  pal_wr_data;
  logic [IDX_W-1:0]  linebuf_idx;
  logic              start_of_line;
  logic              start_of_screen;
  logic [RGB_W-1:0]  linebuf_rgb_data;
  logic [LINE_W-1:0] render_line;
  logic              render_start;

  modport master (
    output lb_wr_en, lb_wr_idx, lb_wr_data,
    output pal_wr_en, pal_wr_addr, pal_wr_data,
    output linebuf_idx, start_of_line, start_of_screen,
    input  linebuf_rgb_data, render_line, render_start
  );

  modport slave (
    input  lb_wr_en, lb_wr_idx, lb_wr_data,
    input  pal_wr_en, pal_wr_addr, pal_wr_data,
    input  linebuf_idx, start_of_line, start_of_screen,
    output linebuf_rgb_data, render_line, render_start
  );

endinterface

// File: rtl/video_linebuf_palette_dpram.sv
// rtl/video_linebuf_palette_dpram.sv - simple dual-port RAM, registered read, old data on collision
module dpram_1w1r
  import video_linebuf_palette_pkg::*;
#(
  parameter int ADDR_W = PIX_W,
  parameter int DATA_W = RGB_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  always_comb begin
    rd_data_d = mem[rd_addr];
  end

  // Read samples the array before this edge's write lands, so a same-address
  // collision returns the old word. Only the read register is reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (!rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/video_linebuf_palette.sv
// rtl/video_linebuf_palette.sv - ping-pong line buffer with palette lookup, 2-clock read latency
module video_linebuf_palette
  import video_linebuf_palette_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  video_linebuf_palette_if.slave  vif
);

  logic              front_sel_d,    front_sel_q;
  logic              rd_sel_d,       rd_sel_q;
  logic [LINE_W-1:0] render_line_d,  render_line_q;
  logic              render_start_d, render_start_q;

  logic              buf0_wr_en;
  logic              buf1_wr_en;
  logic [PIX_W-1:0]  buf0_rd_data;
  logic [PIX_W-1:0]  buf1_rd_data;
  logic [PIX_W-1:0]  pix_r;
  rgb444_t           pal_rgb;

  // The back buffer is the one not selected as front before this edge.
  always_comb begin
    buf0_wr_en = vif.lb_wr_en &  front_sel_q;
    buf1_wr_en = vif.lb_wr_en & ~front_sel_q;
  end

  always_comb begin
    front_sel_d    = front_sel_q;
    render_line_d  = render_line_q;
    render_start_d = vif.start_of_line;
    rd_sel_d       = front_sel_q;
    if (vif.start_of_screen) begin
      front_sel_d   = 1'b1;
      render_line_d = LINE_W'(1);
    end else if (vif.start_of_line) begin
      front_sel_d   = ~front_sel_q;
      render_line_d = next_line(render_line_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      front_sel_q    <= 1'b0;
      rd_sel_q       <= 1'b0;
      render_line_q  <= LINE_W'(1);
      render_start_q <= 1'b0;
    end else begin
      front_sel_q    <= front_sel_d;
      rd_sel_q       <= rd_sel_d;
      render_line_q  <= render_line_d;
      render_start_q <= render_start_d;
    end
  end

  dpram_1w1r #(.ADDR_W(IDX_W), .DATA_W(PIX_W)) buf0 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (buf0_wr_en),
    .wr_addr (vif.lb_wr_idx),
    .wr_data (vif.lb_wr_data),
    .rd_addr (vif.linebuf_idx),
    .rd_data (buf0_rd_data)
  );

  dpram_1w1r #(.ADDR_W(IDX_W), .DATA_W(PIX_W)) buf1 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (buf1_wr_en),
    .wr_addr (vif.lb_wr_idx),
    .wr_data (vif.lb_wr_data),
    .rd_addr (vif.linebuf_idx),
    .rd_data (buf1_rd_data)
  );

  // Both buffers are read every clock; rd_sel_q remembers which was front
  // when the index was sampled, so a swap never tears a read in flight.
  always_comb begin
    pix_r = rd_sel_q ? buf1_rd_data : buf0_rd_data;
  end

  dpram_1w1r #(.ADDR_W(PIX_W), .DATA_W(RGB_W)) palette (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (vif.pal_wr_en),
    .wr_addr (vif.pal_wr_addr),
    .wr_data (vif.pal_wr_data),
    .rd_addr (pix_r),
    .rd_data (pal_rgb)
  );

  assign vif.linebuf_rgb_data = pal_rgb;
  assign vif.render_line      = render_line_q;
  assign vif.render_start     = render_start_q;

endmodule

// File: tb/tb_video_linebuf_palette.sv
// tb/tb_video_linebuf_palette.sv - scoreboard bench for the line buffer and palette
module tb_video_linebuf_palette;
  import video_linebuf_palette_pkg::*;

  typedef struct {
    logic [11:0] rgb;
    bit          v;
  } exp_t;

  logic clk;
  logic rst;
  video_linebuf_palette_if vif ();

  video_linebuf_palette dut (
    .clk (clk),
    .rst (rst),
    .vif (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  exp_t        exp_q[$];
  logic [11:0] pal_m [256];
  bit          pal_v [256];
  logic [7:0]  buf_m [2][1024];
  bit          buf_v [2][1024];
  bit          front_m = 1'b0;
  logic [7:0]  pix_m   = '0;
  bit          pix_v   = 1'b0;
  logic [9:0]  line_m  = 10'd1;
  bit          rs_m    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] pal_init(input int i);
    case (i)
      8'h05:   return 12'hF80;
      8'h07:   return 12'h123;
      8'h11:   return 12'h111;
      8'h22:   return 12'h222;
      8'h33:   return 12'h333;
      default: return 12'((i * 37 + 5) ^ 12'h5A0);
    endcase
  endfunction

  // One clock: model the edge from the current inputs, push the expected RGB,
  // then compare after the edge and drop the single-cycle pulses.
  task automatic step();
    exp_t       e;
    logic [7:0] np;
    bit         npv;
    if (!rst) begin
      e.rgb = '0;  e.v = 1'b1;
      np = '0;     npv = 1'b1;
      front_m = 1'b0; line_m = 10'd1; rs_m = 1'b0;
    end else begin
      e.rgb = pal_m[pix_m];
      e.v   = pix_v && pal_v[pix_m];
      np    = buf_m[front_m][vif.linebuf_idx];
      npv   = buf_v[front_m][vif.linebuf_idx];
      if (vif.lb_wr_en) begin
        buf_m[~front_m][vif.lb_wr_idx] = vif.lb_wr_data;
        buf_v[~front_m][vif.lb_wr_idx] = 1'b1;
      end
      if (vif.pal_wr_en) begin
        pal_m[vif.pal_wr_addr] = vif.pal_wr_data;
        pal_v[vif.pal_wr_addr] = 1'b1;
      end
      rs_m = vif.start_of_line;
      if (vif.start_of_screen) begin
        front_m = 1'b1;
        line_m  = 10'd1;
      end else if (vif.start_of_line) begin
        front_m = ~front_m;
        line_m  = (line_m == 10'(V_TOTAL - 1)) ? 10'd0 : line_m + 10'd1;
      end
    end
    pix_m = np;
    pix_v = npv;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    if (e.v) chk("rgb_model", 32'(vif.linebuf_rgb_data), 32'(e.rgb));
    chk("render_line_model", 32'(vif.render_line), 32'(line_m));
    chk("render_start_model", 32'(vif.render_start), 32'(rs_m));
    vif.lb_wr_en        = 1'b0;
    vif.pal_wr_en       = 1'b0;
    vif.start_of_line   = 1'b0;
    vif.start_of_screen = 1'b0;
  endtask

  task automatic lb_write(input int idx, input logic [7:0] data);
    vif.lb_wr_en   = 1'b1;
    vif.lb_wr_idx  = 10'(idx);
    vif.lb_wr_data = data;
  endtask

  initial begin
    int rs_cnt;
    for (int i = 0; i < 256; i++) pal_v[i] = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 1024; i++) buf_v[b][i] = 1'b0;
    rst = 1'b0;
    vif.lb_wr_en = 1'b0; vif.lb_wr_idx = '0; vif.lb_wr_data = '0;
    vif.pal_wr_en = 1'b0; vif.pal_wr_addr = '0; vif.pal_wr_data = '0;
    vif.linebuf_idx = '0; vif.start_of_line = 1'b0; vif.start_of_screen = 1'b0;
    step();
    step();
    chk("reset_rgb", 32'(vif.linebuf_rgb_data), 32'h0);
    chk("reset_render_line", 32'(vif.render_line), 32'd1);
    chk("reset_render_start", 32'(vif.render_start), 32'd0);
    chk("reset_front_sel", 32'(dut.front_sel_q), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 256; i++) begin
      vif.pal_wr_en = 1'b1; vif.pal_wr_addr = 8'(i); vif.pal_wr_data = pal_init(i);
      step();
    end

    // ping-pong: fill back with 0x11, swap, fill other with 0x22 while reading
    for (int i = 0; i < 1024; i++) begin
      lb_write(i, 8'h11);
      step();
    end
    vif.start_of_line = 1'b1;
    step();
    for (int i = 0; i < 1024; i++) begin
      lb_write(i, 8'h22);
      vif.linebuf_idx = 10'(i);
      step();
      if (i >= 1) chk("pingpong_a", 32'(vif.linebuf_rgb_data), 32'h111);
    end
    vif.start_of_line = 1'b1;
    step();
    for (int i = 0; i < 64; i++) begin
      vif.linebuf_idx = 10'(i);
      step();
      if (i >= 1) chk("pingpong_b", 32'(vif.linebuf_rgb_data), 32'h222);
    end

    // latency: index presented right after the swap edge emerges two clocks later
    lb_write(3, 8'h05);
    vif.linebuf_idx = '0;
    step();
    vif.start_of_line = 1'b1;
    step();
    vif.linebuf_idx = 10'd3;
    step();
    chk("latency_prior", 32'(vif.linebuf_rgb_data), 32'h222);
    step();
    chk("latency_n2", 32'(vif.linebuf_rgb_data), 32'hF80);

    // palette read-during-write returns the old entry
    lb_write(0, 8'h07);
    step();
    vif.start_of_line = 1'b1;
    step();
    vif.linebuf_idx = '0;
    step();
    vif.pal_wr_en = 1'b1; vif.pal_wr_addr = 8'h07; vif.pal_wr_data = 12'hABC;
    step();
    chk("collision_old", 32'(vif.linebuf_rgb_data), 32'h123);
    step();
    chk("collision_new", 32'(vif.linebuf_rgb_data), 32'hABC);

    // write coincident with the swap edge lands in the new front buffer
    lb_write(9, 8'h33);
    vif.start_of_line = 1'b1;
    step();
    vif.linebuf_idx = 10'd9;
    step();
    step();
    chk("swap_edge_write", 32'(vif.linebuf_rgb_data), 32'h333);

    // frame counter and start_of_screen
    vif.start_of_line = 1'b1; vif.start_of_screen = 1'b1;
    step();
    chk("sos_line", 32'(vif.render_line), 32'd1);
    chk("sos_front", 32'(dut.front_sel_q), 32'd1);
    rs_cnt = 0;
    for (int k = 1; k <= V_TOTAL - 1; k++) begin
      vif.start_of_line = 1'b1;
      step();
      if (vif.render_start) rs_cnt++;
      chk("frame_line", 32'(vif.render_line), 32'((1 + k) % V_TOTAL));
      step();
      if (vif.render_start) rs_cnt++;
    end
    chk("render_start_count", 32'(rs_cnt), 32'(V_TOTAL - 1));
    vif.start_of_line = 1'b1; vif.start_of_screen = 1'b1;
    step();
    chk("sos_line_again", 32'(vif.render_line), 32'd1);
    chk("sos_front_again", 32'(dut.front_sel_q), 32'd1);
    chk("sos_render_start", 32'(vif.render_start), 32'd1);

    // reset mid-line while streaming
    for (int i = 0; i < 8; i++) begin
      vif.linebuf_idx = 10'(i + 100);
      step();
    end
    rst = 1'b0;
    vif.start_of_line = 1'b1;
    step();
    chk("midreset_rgb", 32'(vif.linebuf_rgb_data), 32'h0);
    chk("midreset_line", 32'(vif.render_line), 32'd1);
    chk("midreset_rstart", 32'(vif.render_start), 32'd0);
    chk("midreset_front", 32'(dut.front_sel_q), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      vif.linebuf_idx = 10'(i);
      step();
      chk("no_x", 32'($isunknown(vif.linebuf_rgb_data)), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
